// File: rtl/jtag_pkg.sv
// Shared types for the JTAG host: TAP state encoding, command opcodes,
// host sequencer states and the standard TAP next-state function.
package jtag_pkg;

    typedef enum logic [3:0] {
        Exit2DR     = 4'h0,
        Exit1DR     = 4'h1,
        ShiftDR     = 4'h2,
        PauseDR     = 4'h3,
        SelectIR    = 4'h4,
        UpdateDR    = 4'h5,
        CaptureDR   = 4'h6,
        SelectDR    = 4'h7,
        Exit2IR     = 4'h8,
        Exit1IR     = 4'h9,
        ShiftIR     = 4'hA,
        PauseIR     = 4'hB,
        RunTestIdle = 4'hC,
        UpdateIR    = 4'hD,
        CaptureIR   = 4'hE,
        TLReset     = 4'hF
    } tap_state_t;

    typedef enum logic [1:0] {
        OpTlReset = 2'b00,
        OpScanIr  = 2'b01,
        OpScanDr  = 2'b10,
        OpIdle    = 2'b11
    } jtag_op_t;

    typedef enum logic [2:0] {
        HostInit,
        HostIdle,
        HostPre,
        HostShift,
        HostPost,
        HostResp
    } host_state_t;

    // TMS patterns are consumed LSB first; the paired count is pulses minus one.
    localparam logic [5:0] ResetTms   = 6'b011111;
    localparam logic [5:0] PreDrTms   = 6'b000001;
    localparam logic [5:0] PreIrTms   = 6'b000011;
    localparam logic [5:0] PostTms    = 6'b000001;
    localparam logic [2:0] ResetLast  = 3'd5;
    localparam logic [2:0] PreDrLast  = 3'd2;
    localparam logic [2:0] PreIrLast  = 3'd3;
    localparam logic [2:0] PostLast   = 3'd1;

    function automatic tap_state_t tap_next(input tap_state_t state, input logic tms);
        case (state)
            TLReset:     return tms ? TLReset  : RunTestIdle;
            RunTestIdle: return tms ? SelectDR : RunTestIdle;
            SelectDR:    return tms ? SelectIR : CaptureDR;
            CaptureDR:   return tms ? Exit1DR  : ShiftDR;
            ShiftDR:     return tms ? Exit1DR  : ShiftDR;
            Exit1DR:     return tms ? UpdateDR : PauseDR;
            PauseDR:     return tms ? Exit2DR  : PauseDR;
            Exit2DR:     return tms ? UpdateDR : ShiftDR;
            UpdateDR:    return tms ? SelectDR : RunTestIdle;
            SelectIR:    return tms ? TLReset  : CaptureIR;
            CaptureIR:   return tms ? Exit1IR  : ShiftIR;
            ShiftIR:     return tms ? Exit1IR  : ShiftIR;
            Exit1IR:     return tms ? UpdateIR : PauseIR;
            PauseIR:     return tms ? Exit2IR  : PauseIR;
            Exit2IR:     return tms ? UpdateIR : ShiftIR;
            UpdateIR:    return tms ? SelectDR : RunTestIdle;
            default:     return TLReset;
        endcase
    endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: each pulse is CLK_DIV low cycles then CLK_DIV high cycles.
// Strobes are combinational and mark the clk edge at which each event lands.
module jtag_tck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic tck,
    output logic pulse_start,
    output logic rise,
    output logic pulse_done
);
    localparam int CntW = (2 * CLK_DIV > 2) ? $clog2(2 * CLK_DIV) : 1;
    localparam logic [CntW-1:0] RiseCnt = CntW'(CLK_DIV - 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(2 * CLK_DIV - 1);

    logic            active;
    logic [CntW-1:0] cnt;

    assign rise        = active && (cnt == RiseCnt);
    assign pulse_done  = active && (cnt == LastCnt);
    // A held start chains pulses: the next low phase begins on the falling edge.
    assign pulse_start = start && (!active || pulse_done);

    always_ff @(posedge clk) begin
        if (reset) begin
            active <= 1'b0;
            cnt    <= '0;
            tck    <= 1'b0;
        end else if (pulse_start) begin
            active <= 1'b1;
            cnt    <= '0;
            tck    <= 1'b0;
        end else if (pulse_done) begin
            active <= 1'b0;
            cnt    <= '0;
            tck    <= 1'b0;
        end else if (active) begin
            cnt <= cnt + 1'b1;
            if (rise) tck <= 1'b1;
        end
    end

endmodule

// File: rtl/jtag_host.sv
// JTAG initiator: turns IR/DR scan, reset and idle commands into TCK/TMS/TDI
// pulse trains, tracks the target TAP state and returns captured TDO bits.
module jtag_host
    import jtag_pkg::*;
#(
    parameter int MAX_LEN = 32,
    parameter int CLK_DIV = 2,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo,
    output logic [3:0]         tap_state
);
    localparam logic [LEN_W-1:0]   MaxLen  = LEN_W'(MAX_LEN);
    localparam logic [MAX_LEN-1:0] FirstBit = {{(MAX_LEN-1){1'b0}}, 1'b1};

    host_state_t        state;
    jtag_op_t           op;
    tap_state_t         tapState;
    logic [LEN_W-1:0]   lenReg, idx, lenClamped;
    logic [MAX_LEN-1:0] dataReg, bitMask, capMask;
    logic [5:0]         preTms;
    logic [2:0]         preLeft;
    logic               issuing, capShift;
    logic               pulseStart, rise, pulseDone;

    assign tap_state  = tapState;
    assign lenClamped = (cmd_len > MaxLen) ? MaxLen : cmd_len;

    jtag_tck_gen #(.CLK_DIV(CLK_DIV)) tckGen (
        .clk         (clk),
        .reset       (reset),
        .start       (issuing),
        .tck         (tck),
        .pulse_start (pulseStart),
        .rise        (rise),
        .pulse_done  (pulseDone)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HostInit;
            op        <= OpTlReset;
            tapState  <= TLReset;
            lenReg    <= '0;
            idx       <= '0;
            dataReg   <= '0;
            bitMask   <= FirstBit;
            capMask   <= '0;
            preTms    <= ResetTms;
            preLeft   <= ResetLast;
            issuing   <= 1'b1;
            capShift  <= 1'b0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            busy      <= 1'b1;
        end else begin
            rsp_valid <= 1'b0;
            if (rise) begin
                tapState <= tap_next(tapState, tms);
                if (capShift && tdo) rsp_data <= rsp_data | capMask;
            end
            case (state)
                HostIdle: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        op        <= jtag_op_t'(cmd_op);
                        lenReg    <= lenClamped;
                        dataReg   <= cmd_data;
                        rsp_data  <= '0;
                        idx       <= '0;
                        bitMask   <= FirstBit;
                        capShift  <= 1'b0;
                        if (lenClamped == '0) begin
                            state     <= HostResp;
                            rsp_valid <= 1'b1;
                        end else begin
                            issuing <= 1'b1;
                            case (jtag_op_t'(cmd_op))
                                OpScanDr:  begin state <= HostPre; preTms <= PreDrTms; preLeft <= PreDrLast; end
                                OpScanIr:  begin state <= HostPre; preTms <= PreIrTms; preLeft <= PreIrLast; end
                                OpTlReset: begin state <= HostPre; preTms <= ResetTms; preLeft <= ResetLast; end
                                default:   state <= HostShift;
                            endcase
                        end
                    end
                end
                HostResp: begin
                    state     <= HostIdle;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    if (pulseStart) begin
                        if (state != HostShift) begin
                            // Fixed-pattern pulses: init, preamble, reset and postamble.
                            tms      <= preTms[0];
                            tdi      <= 1'b0;
                            capShift <= 1'b0;
                            preTms   <= preTms >> 1;
                            preLeft  <= preLeft - 1'b1;
                            if (preLeft == '0) begin
                                if (state == HostPre && op != OpTlReset) state <= HostShift;
                                else issuing <= 1'b0;
                            end
                        end else begin
                            capShift <= (op != OpIdle);
                            capMask  <= bitMask;
                            bitMask  <= bitMask << 1;
                            dataReg  <= dataReg >> 1;
                            tdi      <= (op != OpIdle) && dataReg[0];
                            idx      <= idx + 1'b1;
                            if (idx == lenReg - 1'b1) begin
                                tms <= (op != OpIdle);
                                if (op == OpIdle) begin
                                    issuing <= 1'b0;
                                end else begin
                                    state   <= HostPost;
                                    preTms  <= PostTms;
                                    preLeft <= PostLast;
                                end
                            end else begin
                                tms <= 1'b0;
                            end
                        end
                    end else if (pulseDone && !issuing) begin
                        if (state == HostInit) begin
                            state     <= HostIdle;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            state     <= HostResp;
                            rsp_valid <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_host.sv
// Directed bench for jtag_host with a pin-level TAP model (8-bit DR, 4-bit IR)
// and a scoreboard of expected response data.
module tb_jtag_host;
  localparam int MAX_LEN = 32;
  localparam int CLK_DIV = 2;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int W       = MAX_LEN;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [W-1:0]     cmd_data = '0;
  logic             rsp_valid;
  logic [W-1:0]     rsp_data;
  logic             busy, tck, tms, tdi;
  logic             tdo = 1'b0;
  logic [3:0]       tap_state;

  jtag_host #(.MAX_LEN(MAX_LEN), .CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo), .tap_state(tap_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // pin monitor and target TAP model
  logic       tms_arr[1024];
  logic       tdi_arr[1024];
  int         rise_cyc[1024];
  int         pulse_total = 0;
  logic       tck_prev = 1'b0;
  logic [3:0] model_state = 4'hF;
  logic [7:0] dr_sh = '0, dr_reg = '0;
  logic [3:0] ir_sh = '0, ir_reg = '0;
  logic [63:0] nxt0 = 64'hCACC_BABA_62CE_3232;
  logic [63:0] nxt1 = 64'hF977_89DD_417F_0155;

  always @(negedge clk) begin
    if (tck && !tck_prev) begin
      if (pulse_total < 1024) begin
        tms_arr[pulse_total]  = tms;
        tdi_arr[pulse_total]  = tdi;
        rise_cyc[pulse_total] = cyc;
      end
      pulse_total = pulse_total + 1;
      case (model_state)
        4'h6: dr_sh = 8'h3C;
        4'h2: dr_sh = {tdi, dr_sh[7:1]};
        4'h5: dr_reg = dr_sh;
        4'hE: ir_sh = 4'b0001;
        4'hA: ir_sh = {tdi, ir_sh[3:1]};
        4'hD: ir_reg = ir_sh;
        default: ;
      endcase
      model_state = tms ? nxt1[{model_state, 2'b00} +: 4] : nxt0[{model_state, 2'b00} +: 4];
    end
    if (!tck && tck_prev)
      tdo = (model_state == 4'h2) ? dr_sh[0] : (model_state == 4'hA) ? ir_sh[0] : 1'b0;
    tck_prev = tck;
  end

  // scoreboard and counters
  logic [W-1:0] exp_q[$];
  int   total = 0;
  int   bad = 0;
  bit   saw_rsp;
  logic prev_tck;
  int   accept_cyc, rsp_cyc, base;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] tms_vec(input int b, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n && i < 64; i++) v[i] = tms_arr[b + i];
    return v;
  endfunction

  function automatic logic [63:0] tdi_vec(input int b, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n && i < 64; i++) v[i] = tdi_arr[b + i];
    return v;
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    saw_rsp  = 1'b0;
    prev_tck = tck;
    while (!cmd_ready && n < 3000) begin
      prev_tck = tck;
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1'b1;
      n++;
    end
    if (!cmd_ready) check({tag, "_ready_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic send_cmd(input logic [1:0] op, input int len, input logic [W-1:0] data);
    wait_ready("send");
    base      = pulse_total;
    cmd_op    = op;
    cmd_len   = LEN_W'(len);
    cmd_data  = data;
    cmd_valid = 1'b1;
    accept_cyc = cyc;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    logic [W-1:0] e;
    while (!rsp_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) begin
      check({tag, "_rsp_timeout"}, 64'd0, 64'd1);
    end else begin
      rsp_cyc = cyc;
      if (exp_q.size() == 0) check({tag, "_unexpected_rsp"}, 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        check({tag, "_rsp_data"}, 64'(rsp_data), 64'(e));
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [W-1:0] big;
    int accepts, rsps, rsps_at_second;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_tck", 64'(tck), 64'd0);
    check("rst_tms", 64'(tms), 64'd1);
    check("rst_tdi", 64'(tdi), 64'd0);
    check("rst_ready", 64'(cmd_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_tap", 64'(tap_state), 64'hF);

    // init sequence
    base  = pulse_total;
    reset = 1'b0;
    wait_ready("init");
    check("init_pulses", 64'(pulse_total - base), 64'd6);
    check("init_tms", tms_vec(base, 6), 64'h1F);
    check("init_period_first", 64'(rise_cyc[base + 1] - rise_cyc[base]), 64'(2 * CLK_DIV));
    check("init_period_last", 64'(rise_cyc[base + 5] - rise_cyc[base + 4]), 64'(2 * CLK_DIV));
    check("init_ready_after_fall", {62'd0, prev_tck, tck}, 64'b10);
    check("init_no_rsp", 64'(saw_rsp), 64'd0);
    check("init_tap", 64'(tap_state), 64'hC);
    check("init_busy", 64'(busy), 64'd0);

    // SCAN_DR len=8
    exp_q.push_back(32'h3C);
    send_cmd(2'b10, 8, 32'hA5);
    check("dr8_ready_drop", 64'(cmd_ready), 64'd0);
    wait_rsp("dr8");
    check("dr8_pulses", 64'(pulse_total - base), 64'd13);
    check("dr8_tms", tms_vec(base, 13), 64'hC01);
    check("dr8_tdi", tdi_vec(base, 13), 64'h528);
    check("dr8_model_dr", 64'(dr_reg), 64'hA5);
    check("dr8_tap", 64'(tap_state), 64'hC);
    check("dr8_model_tap", 64'(model_state), 64'hC);
    repeat (4) @(negedge clk);
    check("dr8_rsp_hold", 64'(rsp_data), 64'h3C);

    // SCAN_IR len=4
    exp_q.push_back(32'h1);
    send_cmd(2'b01, 4, 32'h9);
    wait_rsp("ir4");
    check("ir4_pulses", 64'(pulse_total - base), 64'd10);
    check("ir4_tms", tms_vec(base, 10), 64'h183);
    check("ir4_tdi", tdi_vec(base, 10), 64'h90);
    check("ir4_model_ir", 64'(ir_reg), 64'h9);
    check("ir4_tap", 64'(tap_state), 64'hC);

    // IDLE len=3
    exp_q.push_back(32'h0);
    send_cmd(2'b11, 3, 32'hFFFF_FFFF);
    wait_rsp("idle3");
    check("idle3_pulses", 64'(pulse_total - base), 64'd3);
    check("idle3_tms", tms_vec(base, 3), 64'h0);
    check("idle3_tdi", tdi_vec(base, 3), 64'h0);
    check("idle3_tap", 64'(tap_state), 64'hC);

    // SCAN_DR len=0
    exp_q.push_back(32'h0);
    send_cmd(2'b10, 0, 32'h1234_5678);
    wait_rsp("dr0");
    check("dr0_latency", 64'(rsp_cyc - accept_cyc), 64'd1);
    check("dr0_pulses", 64'(pulse_total - base), 64'd0);

    // SCAN_DR len=40 (clamped), cmd_valid held across two commands
    big = 32'hDEAD_BEEF;
    exp_q.push_back((big << 8) | 32'h3C);
    exp_q.push_back((big << 8) | 32'h3C);
    wait_ready("held");
    base = pulse_total;
    cmd_op = 2'b10; cmd_len = LEN_W'(40); cmd_data = big; cmd_valid = 1'b1;
    accepts = 0; rsps = 0; rsps_at_second = -1;
    for (int c = 0; c < 3000 && rsps < 2; c++) begin
      if (rsp_valid) begin
        check("held_rsp_data", 64'(rsp_data), 64'(exp_q.pop_front()));
        rsps++;
      end
      if (cmd_valid && cmd_ready) begin
        accepts++;
        if (accepts == 2) begin
          rsps_at_second = rsps;
          @(posedge clk);
          #1 cmd_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("held_rsps", 64'(rsps), 64'd2);
    check("held_accepts", 64'(accepts), 64'd2);
    check("held_order", 64'(rsps_at_second), 64'd1);
    check("held_pulses", 64'(pulse_total - base), 64'd74);
    repeat (3) @(negedge clk);
    check("held_no_third", 64'(cmd_ready), 64'd1);

    // reset during the 5th shift pulse of a len=8 DR scan
    send_cmd(2'b10, 8, 32'h5A);
    for (int c = 0; c < 500 && (pulse_total - base) < 8; c++) @(negedge clk);
    check("mid_reached_shift5", 64'(pulse_total - base), 64'd8);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_tck", 64'(tck), 64'd0);
    check("mid_tms", 64'(tms), 64'd1);
    check("mid_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rsp_data", 64'(rsp_data), 64'd0);
    check("mid_busy", 64'(busy), 64'd1);
    check("mid_tap", 64'(tap_state), 64'hF);
    @(negedge clk);
    @(negedge clk);
    base  = pulse_total;
    reset = 1'b0;
    wait_ready("mid_init");
    check("mid_init_pulses", 64'(pulse_total - base), 64'd6);
    check("mid_init_tms", tms_vec(base, 6), 64'h1F);
    check("mid_no_rsp", 64'(saw_rsp), 64'd0);
    check("mid_ready", 64'(cmd_ready), 64'd1);
    check("mid_tap_end", 64'(tap_state), 64'hC);
    check("mid_model_tap", 64'(model_state), 64'hC);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
